// File: rtl/ir_pkg.sv
// Shared instruction-word constants for the fetch queue and the decoder.
package ir_pkg;

  localparam int INSTR_W_DEF  = 16;
  localparam int OPCODE_W_DEF = 4;
  localparam int REST_W_DEF   = INSTR_W_DEF - OPCODE_W_DEF;

  // Width of the non-opcode field for a given word/opcode width pair.
  function automatic int rest_width(input int instr_w, input int opcode_w);
    return instr_w - opcode_w;
  endfunction

endpackage

// File: rtl/ir_split.sv
// Combinational opcode/rest field extractor for one instruction word.
module ir_split
  import ir_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  localparam int REST_W  = rest_width(INSTR_W, OPCODE_W)
) (
  input  logic [INSTR_W-1:0]  word,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REST_W-1:0]   rest
);

  // Opcode lives in the MSBs, everything below it is the operand field.
  assign opcode = word[INSTR_W-1 -: OPCODE_W];
  assign rest   = word[REST_W-1:0];

endmodule

// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: a small FIFO whose head word is
// presented already split into opcode and rest fields.
module ir_queue
  import ir_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int DEPTH    = 4,
  localparam int REST_W  = rest_width(INSTR_W, OPCODE_W),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REST_W-1:0]   rest,
  output logic [CNT_W-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ir_queue: DEPTH must be a power of two and at least 2");
    end
    if (OPCODE_W >= INSTR_W) begin : g_bad_opcode_w
      $error("ir_queue: OPCODE_W must be smaller than INSTR_W");
    end
  endgenerate

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head_word;

  // Handshake status comes straight from the registered occupancy, so a pop
  // on a full queue cannot open in_ready within the same cycle.
  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Empty queue shows an all-zero head so stale storage is never visible.
  assign head_word = out_valid ? mem[rd_ptr_reg] : '0;

  // Pointer and occupancy update; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage write; contents need no reset because empty slots are masked.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= instruction;
  end

  ir_split #(
    .INSTR_W (INSTR_W),
    .OPCODE_W(OPCODE_W)
  ) u_split (
    .word  (head_word),
    .opcode(opcode),
    .rest  (rest)
  );

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: vector table, scoreboard stream, and
// hand-written flush / async-reset / wide-parameter sequences.
module tb_ir_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [11:0] rest;
  logic [2:0]  count;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_instr;
  logic        w_flush;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [6:0]  w_opcode;
  logic [24:0] w_rest;
  logic [3:0]  w_count;

  int n_cmp;
  int n_fail;
  logic [15:0] sb[$];

  ir_queue u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instruction(instruction),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .opcode     (opcode),
    .rest       (rest),
    .count      (count)
  );

  ir_queue #(.INSTR_W(32), .OPCODE_W(7), .DEPTH(8)) u_wide (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (w_in_valid),
    .in_ready   (w_in_ready),
    .instruction(w_instr),
    .flush      (w_flush),
    .out_valid  (w_out_valid),
    .out_ready  (w_out_ready),
    .opcode     (w_opcode),
    .rest       (w_rest),
    .count      (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] instr;
    logic        ordy;
    logic        fl;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic [3:0]  e_op;
    logic [11:0] e_rest;
    logic        e_ir;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One scoreboard cycle: check current outputs against the model, drive the
  // inputs, clock, then apply the transfers the model predicted.
  task automatic cycle(input logic iv, input logic [15:0] w, input logic ordy, input logic fl);
    logic [15:0] hd;
    bit do_push;
    bit do_pop;
    in_valid    = iv;
    instruction = w;
    out_ready   = ordy;
    flush       = fl;
    hd = (sb.size() != 0) ? sb[0] : 16'h0000;
    chk("sb_out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("sb_opcode",    32'(opcode),    32'(hd[15:12]));
    chk("sb_rest",      32'(rest),      32'(hd[11:0]));
    chk("sb_count",     32'(count),     32'(sb.size()));
    chk("sb_in_ready",  32'(in_ready),  32'(sb.size() < 4));
    do_push = iv && (sb.size() < 4);
    do_pop  = ordy && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      $display("flush (dropped %0d entries)", sb.size());
      sb.delete();
    end else begin
      if (do_pop) begin
        $display("pop  %h", hd);
        void'(sb.pop_front());
      end
      if (do_push) sb.push_back(w);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    instruction = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    w_in_valid  = 1'b0;
    w_instr     = '0;
    w_flush     = 1'b0;
    w_out_ready = 1'b0;

    //               iv    instr     ordy  fl    cnt   ov    op     rest     ir
    vecs[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 3'd1, 1'b1, 4'h1, 12'h234, 1'b1};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0, 12'h000, 1'b1};
    vecs[2]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 3'd1, 1'b1, 4'hA, 12'h001, 1'b1};
    vecs[3]  = '{1'b1, 16'hB002, 1'b0, 1'b0, 3'd2, 1'b1, 4'hA, 12'h001, 1'b1};
    vecs[4]  = '{1'b1, 16'hC003, 1'b0, 1'b0, 3'd3, 1'b1, 4'hA, 12'h001, 1'b1};
    vecs[5]  = '{1'b1, 16'hD004, 1'b0, 1'b0, 3'd4, 1'b1, 4'hA, 12'h001, 1'b0};
    vecs[6]  = '{1'b1, 16'hE005, 1'b0, 1'b0, 3'd4, 1'b1, 4'hA, 12'h001, 1'b0};
    vecs[7]  = '{1'b1, 16'hE005, 1'b1, 1'b0, 3'd3, 1'b1, 4'hB, 12'h002, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 1'b1, 4'hC, 12'h003, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b1, 4'hD, 12'h004, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0, 12'h000, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0, 12'h000, 1'b1};

    // Values while reset is held
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_opcode",    32'(opcode),    32'h0);
    chk("rst_rest",      32'(rest),      32'h0);
    chk("rst_count",     32'(count),     32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: basic push, fill to full, ignored push, ordered drain
    for (int i = 0; i < 12; i++) begin
      in_valid    = vecs[i].iv;
      instruction = vecs[i].instr;
      out_ready   = vecs[i].ordy;
      flush       = vecs[i].fl;
      @(posedge clk);
      #1;
      $display("vec %0d: iv=%b in=%h ordy=%b -> cnt=%0d ov=%b op=%h rest=%h ir=%b",
               i, vecs[i].iv, vecs[i].instr, vecs[i].ordy, count, out_valid, opcode, rest, in_ready);
      chk("vec_count",     32'(count),     32'(vecs[i].e_cnt));
      chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].e_ov));
      chk("vec_opcode",    32'(opcode),    32'(vecs[i].e_op));
      chk("vec_rest",      32'(rest),      32'(vecs[i].e_rest));
      chk("vec_in_ready",  32'(in_ready),  32'(vecs[i].e_ir));
    end

    // Sustained push+pop across the pointer wrap
    sb.delete();
    cycle(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) cycle(1'b1, 16'(i * 16'h1001), 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Flush with 3 entries and a same-cycle push of F00F
    cycle(1'b1, 16'h1111, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 1'b0);
    cycle(1'b1, 16'h3333, 1'b0, 1'b0);
    cycle(1'b1, 16'hF00F, 1'b1, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic including occasional flushes
    for (int i = 0; i < 80; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    end
    while (sb.size() != 0) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset pulse between edges with 2 entries queued
    cycle(1'b1, 16'h4AAA, 1'b0, 1'b0);
    cycle(1'b1, 16'h5BBB, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'h2);
    rst_n = 1'b0;
    #2;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_opcode",    32'(opcode),    32'h0);
    chk("arst_rest",      32'(rest),      32'h0);
    chk("arst_count",     32'(count),     32'h0);
    chk("arst_in_ready",  32'(in_ready),  32'h1);
    #2;
    rst_n = 1'b1;
    sb.delete();
    cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Wide parameter set: 32-bit words, 7-bit opcode, depth 8
    w_in_valid = 1'b1;
    w_instr    = 32'hFE00_0013;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    $display("wide push %h -> op=%h rest=%h cnt=%0d", w_instr, w_opcode, w_rest, w_count);
    chk("wide_out_valid", 32'(w_out_valid), 32'h1);
    chk("wide_opcode",    32'(w_opcode),    32'h7F);
    chk("wide_rest",      32'(w_rest),      32'h0000013);
    chk("wide_count",     32'(w_count),     32'h1);
    w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    w_out_ready = 1'b0;
    chk("wide_pop_count", 32'(w_count),  32'h0);
    chk("wide_pop_op",    32'(w_opcode), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter INSTR_W, default 16: instruction word width in bits.
REQ-002 Parameter OPCODE_W, default 4: opcode field width, taken from the instruction MSBs; REST_W = INSTR_W - OPCODE_W.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  producer offers an instruction word this cycle.
REQ-007 in_ready  output  1  queue can accept a word this cycle.
REQ-008 instruction  input  INSTR_W  incoming instruction word.
REQ-009 flush  input  1  discard all queued words, e.g. on a taken branch.
REQ-010 out_valid  output  1  head entry is present.
REQ-011 out_ready  input  1  consumer (decoder) takes the head this cycle.
REQ-012 opcode  output  OPCODE_W  instruction[INSTR_W-1 -: OPCODE_W] of the head entry.
REQ-013 rest  output  REST_W  instruction[REST_W-1:0] of the head entry.
REQ-014 count  output  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-015 Push occurs when in_valid and in_ready are both high at a rising edge; pop occurs when out_valid and out_ready are both high.
REQ-016 Latency: a word pushed at edge N appears at opcode/rest with out_valid high after edge N; there is no same-cycle bypass from instruction to outputs.
REQ-017 Order is strictly FIFO; the opcode/rest split is applied to the stored word, with no reordering or modification.
REQ-018 in_ready = (count < DEPTH); when full, a simultaneous pop does not raise in_ready in the same cycle.
REQ-019 out_valid = (count != 0); opcode and rest are all-zero when out_valid is low.
REQ-020 Simultaneous push and pop leaves count unchanged and advances both pointers.
REQ-021 Read and write pointers wrap modulo DEPTH with no bubble at the wrap point.
REQ-022 A pop while empty and a push while full are ignored; no state changes.
REQ-023 flush at an edge sets count to 0 and resets both pointers to 0; it overrides a same-cycle push (the word is dropped) and a same-cycle pop.
REQ-024 After flush, out_valid is low for at least the next cycle; in_ready is high.
REQ-025 out_valid, opcode, rest and count are glitch-free functions of registered state only.

Reset
REQ-026 While rst_n is low: count=0, pointers=0, out_valid=0, opcode=0, rest=0, in_ready=1.
REQ-027 Reset asserted mid-operation takes effect immediately (asynchronously), and all queued contents are lost.
REQ-028 Storage array contents need no reset; they are never observable while the entry is empty.
REQ-029 The first push may occur at the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package ir_pkg holds the default INSTR_W and OPCODE_W constants and a REST_W derivation, reused by the decoder.
REQ-031 One sub-module, ir_split, is instantiated on the head word: a combinational opcode/rest field extractor parametrised by INSTR_W/OPCODE_W.
REQ-032 Elaboration rejects DEPTH that is not a power of two, and OPCODE_W >= INSTR_W.

Verification
REQ-033 Reset, then push 0x1234 -> next cycle out_valid=1, opcode=0x1, rest=0x234, count=1.
REQ-034 Push 0xA001, 0xB002, 0xC003, 0xD004 with out_ready=0 -> count=4 and in_ready=0; a fifth push of 0xE005 is ignored; pops yield opcodes A, B, C, D in order.
REQ-035 Sustained push and pop every cycle for 10 words 0x0000..0x9009 -> count stays 1; outputs appear in order across the pointer wrap.
REQ-036 With 3 entries, assert flush together with a push of 0xF00F -> next cycle count=0 and out_valid=0; 0xF00F never appears at the outputs.
REQ-037 With 2 entries, pulse rst_n low between edges -> out_valid, opcode, rest and count go to 0 before the next edge.
REQ-038 Parameter sweep INSTR_W=32, OPCODE_W=7, DEPTH=8: push 0xFE00_0013 -> opcode=0x7F, rest=0x0000013.
